// File: rtl/adder_pkg.sv
// Shared constants and response layout for the shared adder8 datapath.
// Imported by the arbiter wrapper and its sub-modules.
package adder_pkg;

  localparam int DATA_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Arithmetic part of a response; the requester id is carried separately
  // because its width depends on the NREQ parameter of the instantiating block.
  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              carry;
    logic              ovf;
  } rsp_data_t;

endpackage

// File: rtl/adder8.sv
// 8-bit add/sub unit: y = a + b (sub=0) or a - b (sub=1), mod 2^8.
// For subtract, carry out = 1 means no borrow.
module adder8
  import adder_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  logic [DATA_W-1:0] w_bx;
  logic [DATA_W:0]   w_sum;

  // Subtract is a + ~b + 1, with the +1 entering as carry-in.
  assign w_bx  = sub ? ~b : b;
  assign w_sum = {1'b0, a} + {1'b0, w_bx} + {{DATA_W{1'b0}}, sub};
  assign y     = w_sum[DATA_W-1:0];
  assign cout  = w_sum[DATA_W];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps to 0.
// It produces a one-hot grant and the encoded winner id. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic            stall,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  int   w_idx;
  logic w_found;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    if (!stall) begin
      for (int k = 0; k < NREQ; k++) begin
        w_idx = int'(ptr) + k;
        if (w_idx >= NREQ) w_idx = w_idx - NREQ;
        if (!w_found && req[w_idx]) begin
          gnt[w_idx] = 1'b1;
          gnt_id     = IDW'(w_idx);
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder8_share_arb.sv
// Shares a single adder8 among NREQ requesters through a round-robin arbiter.
// Two registered stages (issue, response) give the results, tagged with the requester id.
module adder8_share_arb
  import adder_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] a_in,
  input  logic [NREQ*DATA_W-1:0] b_in,
  input  logic [NREQ-1:0]        sub_in,
  output logic [NREQ-1:0]        gnt,
  input  logic                   stall,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_y,
  output logic                   rsp_carry,
  output logic                   rsp_ovf
);

  logic [IDW-1:0]    r_ptr;
  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_gid;
  logic              w_xfer;
  logic [DATA_W-1:0] w_a_sel, w_b_sel;
  logic              w_sub_sel;

  logic              r_v1;
  logic [IDW-1:0]    r_id1;
  logic [DATA_W-1:0] r_a1, r_b1;
  logic              r_sub1;

  logic              r_v2;
  logic [IDW-1:0]    r_id2;
  rsp_data_t         r_rsp2;

  logic [DATA_W-1:0] w_y, w_bx;
  logic              w_cout, w_ovf;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req),
    .stall  (stall),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gid)
  );

  // The arbiter already suppresses grants under stall, so any grant is a transfer.
  assign w_xfer = |(w_gnt & req);

  always_comb begin
    w_a_sel   = '0;
    w_b_sel   = '0;
    w_sub_sel = OP_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_a_sel   = a_in[i*DATA_W +: DATA_W];
        w_b_sel   = b_in[i*DATA_W +: DATA_W];
        w_sub_sel = sub_in[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_id1  <= '0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_sub1 <= OP_ADD;
    end else if (!stall) begin
      r_v1 <= w_xfer;
      if (w_xfer) begin
        r_id1  <= w_gid;
        r_a1   <= w_a_sel;
        r_b1   <= w_b_sel;
        r_sub1 <= w_sub_sel;
      end
    end
  end

  adder8 u_add (
    .a    (r_a1),
    .b    (r_b1),
    .sub  (r_sub1),
    .y    (w_y),
    .cout (w_cout)
  );

  // Signed overflow: operands agree in sign but the result does not.
  assign w_bx  = r_sub1 ? ~r_b1 : r_b1;
  assign w_ovf = (r_a1[DATA_W-1] == w_bx[DATA_W-1]) & (w_y[DATA_W-1] != r_a1[DATA_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_id2  <= '0;
      r_rsp2 <= '0;
    end else if (!stall) begin
      r_v2         <= r_v1;
      r_id2        <= r_id1;
      r_rsp2.y     <= w_y;
      r_rsp2.carry <= w_cout;
      r_rsp2.ovf   <= w_ovf;
    end
  end

  assign gnt       = w_gnt;
  assign rsp_valid = r_v2;
  assign rsp_id    = r_id2;
  assign rsp_y     = r_rsp2.y;
  assign rsp_carry = r_rsp2.carry;
  assign rsp_ovf   = r_rsp2.ovf;

endmodule

// File: tb/tb_adder8_share_arb.sv
// Directed bench for adder8_share_arb: single-op vector table, then round-robin,
// stall and mid-operation reset sequences with hand-computed expectations.
module tb_adder8_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [31:0]     a_in, b_in;
  logic [3:0]      sub_in;
  logic [3:0]      gnt;
  logic            stall;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_y;
  logic            rsp_carry, rsp_ovf;

  int n_run  = 0;
  int n_fail = 0;

  adder8_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .sub_in    (sub_in),
    .gnt       (gnt),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] y;
    logic       c;
    logic       o;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string name, input logic v, input int id, input logic [7:0] y,
                         input logic c, input logic o);
    chk({name, ".valid"}, 32'(rsp_valid), 32'(v));
    if (v) begin
      chk({name, ".id"},    32'(rsp_id),    32'(id));
      chk({name, ".y"},     32'(rsp_y),     32'(y));
      chk({name, ".carry"}, 32'(rsp_carry), 32'(c));
      chk({name, ".ovf"},   32'(rsp_ovf),   32'(o));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst.valid", 32'(rsp_valid), 0);
    chk("rst.id",    32'(rsp_id),    0);
    chk("rst.y",     32'(rsp_y),     0);
    chk("rst.flags", 32'({rsp_carry, rsp_ovf}), 0);
    step();
    rst = 1'b0;
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{0, 8'd5,   8'd5,  1'b0, 8'd10,  1'b0, 1'b0};
    vt[1] = '{1, 8'd8,   8'd5,  1'b1, 8'd3,   1'b1, 1'b0};
    vt[2] = '{2, 8'd5,   8'd8,  1'b1, 8'hFD,  1'b0, 1'b0};
    vt[3] = '{3, 8'd127, 8'd1,  1'b0, 8'h80,  1'b0, 1'b1};
    vt[4] = '{0, 8'h80,  8'd1,  1'b1, 8'd127, 1'b1, 1'b1};
    vt[5] = '{1, 8'hFF,  8'd1,  1'b0, 8'h00,  1'b1, 1'b0};
    vt[6] = '{2, 8'h00,  8'h00, 1'b1, 8'h00,  1'b1, 1'b0};

    rst = 1'b1; req = '0; a_in = '0; b_in = '0; sub_in = '0; stall = 1'b0;
    #2;
    chk("init.gnt", 32'(gnt), 0);
    step();
    do_reset();

    // Single-op vectors: grant same cycle, result two edges later, operands scrambled after the edge.
    for (int i = 0; i < 7; i++) begin
      req = 4'(1 << vt[i].id);
      a_in = $urandom; b_in = $urandom; sub_in = 4'($urandom);
      a_in[8*vt[i].id +: 8] = vt[i].a;
      b_in[8*vt[i].id +: 8] = vt[i].b;
      sub_in[vt[i].id]      = vt[i].sub;
      #1;
      chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(1 << vt[i].id));
      step();
      req = '0; a_in = $urandom; b_in = $urandom; sub_in = 4'($urandom);
      #1;
      chk($sformatf("vec%0d.early", i), 32'(rsp_valid), 0);
      step();
      chk_rsp($sformatf("vec%0d", i), 1'b1, vt[i].id, vt[i].y, vt[i].c, vt[i].o);
      step();
      chk($sformatf("vec%0d.once", i), 32'(rsp_valid), 0);
    end

    // Round robin, all requesters continuously for 8 cycles.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a_in[8*k +: 8] = 8'(k);
      b_in[8*k +: 8] = 8'h10;
    end
    sub_in = '0;
    for (int c = 0; c < 11; c++) begin
      req = (c < 8) ? 4'hF : 4'h0;
      #1;
      chk($sformatf("rr%0d.gnt", c), 32'(gnt), (c < 8) ? 32'(1 << (c % 4)) : 0);
      if (c >= 2 && c < 10)
        chk_rsp($sformatf("rr%0d", c), 1'b1, (c - 2) % 4, 8'(8'h10 + (c - 2) % 4), 1'b0, 1'b0);
      else
        chk($sformatf("rr%0d.valid", c), 32'(rsp_valid), 0);
      step();
    end

    // Stall with two ops in flight; pointer is 0 here.
    a_in[7:0]  = 8'd1; b_in[7:0]  = 8'd1;
    a_in[15:8] = 8'd2; b_in[15:8] = 8'd2;
    req = 4'b0011;
    #1; chk("st.gnt0", 32'(gnt), 32'b0001);
    step();
    #1; chk("st.gnt1", 32'(gnt), 32'b0010);
    step();
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("st%0d.gnt", s), 32'(gnt), 0);
      chk_rsp($sformatf("st%0d", s), 1'b1, 0, 8'd2, 1'b0, 1'b0);
      step();
    end
    stall = 1'b0; req = '0;
    #1; chk_rsp("st.rel0", 1'b1, 0, 8'd2, 1'b0, 1'b0);
    step(); chk_rsp("st.rel1", 1'b1, 1, 8'd4, 1'b0, 1'b0);
    step(); chk("st.rel2.valid", 32'(rsp_valid), 0);
    step(); chk("st.rel3.valid", 32'(rsp_valid), 0);

    // Reset with both stages occupied; pointer is 2 here.
    req = 4'b0100;
    #1; chk("mr.gnt0", 32'(gnt), 32'b0100);
    step();
    req = 4'b1000;
    #1; chk("mr.gnt1", 32'(gnt), 32'b1000);
    step();
    req = '0;
    #1; chk("mr.full", 32'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("mr.rst.valid", 32'(rsp_valid), 0);
    chk("mr.rst.id",    32'(rsp_id),    0);
    step();
    rst = 1'b0; req = 4'b1010;
    a_in[15:8] = 8'd20; b_in[15:8] = 8'd3; sub_in[1] = 1'b1;
    #1; chk("mr.gnt", 32'(gnt), 32'b0010);
    step();
    req = '0;
    #1; chk("mr.post0.valid", 32'(rsp_valid), 0);
    step(); chk_rsp("mr.post1", 1'b1, 1, 8'd17, 1'b1, 1'b0);
    step(); chk("mr.post2.valid", 32'(rsp_valid), 0);
    step(); chk("mr.post3.valid", 32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
